// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO register block: bus width, register
// indices and the bus data type used by the register file and its bench.
package gpio_pkg;

  // Width of the register bus; every register is presented on 8 bits.
  localparam int BUS_W = 8;

  // Register indices as decoded from REGSEL.
  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_DIR      = 2'd1,
    REG_IRQ_EN   = 2'd2,
    REG_IRQ_STAT = 2'd3
  } reg_sel_e;

  typedef logic [BUS_W-1:0] bus_t;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for the asynchronous pad inputs. All stages are
// cleared by the synchronous reset so the edge detector downstream starts
// from a known all-zero view of the pins.
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Shift the pad value through the synchronizer chain.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value; blocking here would collapse
  // the chain into a single flop.
  // NOTE: these stages are discrete flops, so resetting the whole array is
  // cheap and intended; a RAM-style storage array would not be reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_regs.sv
// GPIO register block: DATA / DIR / IRQ_EN / IRQ_STAT registers on an
// 8-bit bus, synchronized pad inputs with any-edge detection, sticky
// write-1-to-clear status and a registered level interrupt.
module gpio_regs
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       REGSEL,
  input  logic             BUSW,
  input  logic             BUSEN,
  input  logic [BUS_W-1:0] BUSWDATA,
  output logic [BUS_W-1:0] BUSRDATA,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  reg_sel_e         sel;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_stat_q;
  logic [WIDTH-1:0] irq_stat_next;

  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] pin_hist_q;
  logic             armed_q;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] w1c_mask;

  bus_t             rdata_next;

  assign sel     = reg_sel_e'(REGSEL);
  assign wr_en   = BUSEN & BUSW;
  assign wr_data = BUSWDATA[WIDTH-1:0];

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (gpio_in),
    .sync_out (pin_sync)
  );

  // Edge detect: any difference between the synchronized pins and the
  // history flop is an edge. The first cycle out of reset only primes the
  // history flop and never reports an edge.
  assign edge_hit = armed_q ? (pin_sync ^ pin_hist_q) : '0;

  // Write-1-to-clear mask, only live during a write to IRQ_STAT.
  assign w1c_mask = (wr_en && sel == REG_IRQ_STAT) ? wr_data : '0;

  // Clear first, then OR in new edges so a simultaneous edge wins.
  assign irq_stat_next = (irq_stat_q & ~w1c_mask) | edge_hit;

  // Read mux for the registered read port, zero-extended to the bus width.
  // NOTE: rdata_next gets a full default before the case; without it any
  // path that skipped an assignment would infer a latch.
  always_comb begin
    rdata_next = '0;
    unique case (sel)
      REG_DATA:     rdata_next[WIDTH-1:0] = pin_sync;
      REG_DIR:      rdata_next[WIDTH-1:0] = dir_q;
      REG_IRQ_EN:   rdata_next[WIDTH-1:0] = irq_en_q;
      REG_IRQ_STAT: rdata_next[WIDTH-1:0] = irq_stat_q;
      default:      rdata_next            = '0;
    endcase
  end

  // Bus-writable control registers: output data, direction and enables.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= '0;
      dir_q    <= '0;
      irq_en_q <= '0;
    end else if (wr_en) begin
      unique case (sel)
        REG_DATA:   data_q   <= wr_data;
        REG_DIR:    dir_q    <= wr_data;
        REG_IRQ_EN: irq_en_q <= wr_data;
        default:    ;
      endcase
    end
  end

  // Pin history and the one-shot arm flag used to skip the first cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_hist_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      pin_hist_q <= pin_sync;
      armed_q    <= 1'b1;
    end
  end

  // Sticky edge status, independent of IRQ_EN and of pin direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_stat_q <= '0;
    end else begin
      irq_stat_q <= irq_stat_next;
    end
  end

  // Registered interrupt from the current status and enables.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(irq_stat_q & irq_en_q);
    end
  end

  // Read data refreshes every cycle from whatever REGSEL addresses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BUSRDATA <= '0;
    end else begin
      BUSRDATA <= rdata_next;
    end
  end

  assign gpio_out = data_q;
  assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_gpio_regs.sv
// Self-checking bench for gpio_regs: directed bus traffic with expected
// read data queued at issue time and compared by an independent monitor.
module tb_gpio_regs;
  import gpio_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] REGSEL;
  logic       BUSW;
  logic       BUSEN;
  logic [7:0] BUSWDATA;
  logic [7:0] gpio_in;

  logic [7:0] rdata8;
  logic [7:0] gpio_out8;
  logic [7:0] gpio_oe8;
  logic       irq8;

  logic [7:0] rdata4;
  logic [3:0] gpio_out4;
  logic [3:0] gpio_oe4;
  logic       irq4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  bit   rd_seen = 1'b0;

  logic [7:0] exp_stat_seq [4] = '{8'h00, 8'h00, 8'h00, 8'h01};
  logic       exp_irq_seq  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  gpio_regs #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .REGSEL   (REGSEL),
    .BUSW     (BUSW),
    .BUSEN    (BUSEN),
    .BUSWDATA (BUSWDATA),
    .BUSRDATA (rdata8),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out8),
    .gpio_oe  (gpio_oe8),
    .irq      (irq8)
  );

  gpio_regs #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .REGSEL   (REGSEL),
    .BUSW     (BUSW),
    .BUSEN    (BUSEN),
    .BUSWDATA (BUSWDATA),
    .BUSRDATA (rdata4),
    .gpio_in  (gpio_in[3:0]),
    .gpio_out (gpio_out4),
    .gpio_oe  (gpio_oe4),
    .irq      (irq4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    BUSEN = 1'b0;
    BUSW  = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input reg_sel_e sel, input logic [7:0] d);
    REGSEL   = sel;
    BUSWDATA = d;
    BUSW     = 1'b1;
    BUSEN    = 1'b1;
    @(negedge clk);
    BUSEN    = 1'b0;
    BUSW     = 1'b0;
  endtask

  task automatic bus_read(input reg_sel_e sel, input logic [7:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    REGSEL = sel;
    BUSW   = 1'b0;
    BUSEN  = 1'b1;
    @(negedge clk);
    BUSEN  = 1'b0;
  endtask

  // Note which edges captured a read strobe.
  always @(posedge clk) begin
    rd_seen <= BUSEN && !BUSW && rst_n;
  end

  // Monitor: read data is presented one cycle after the strobe.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: read data %0h with nothing expected", rdata8);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, rdata8, e.exp);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    REGSEL   = 2'd0;
    BUSW     = 1'b0;
    BUSEN    = 1'b0;
    BUSWDATA = 8'h00;
    gpio_in  = 8'hFF;

    // Reset held three cycles with all pins high.
    repeat (3) @(negedge clk);
    check("rst_rdata8", rdata8, 8'h00);
    check("rst_out8",   gpio_out8, 8'h00);
    check("rst_oe8",    gpio_oe8, 8'h00);
    check("rst_irq8",   irq8, 1'b0);
    check("rst_rdata4", rdata4, 8'h00);
    check("rst_oe4",    gpio_oe4, 4'h0);

    // Release with pins low: nothing should ever reach the status.
    rst_n   = 1'b1;
    gpio_in = 8'h00;
    bus_read(REG_IRQ_STAT, 8'h00, "stat_after_rst_a");
    bus_read(REG_IRQ_STAT, 8'h00, "stat_after_rst_b");
    bus_read(REG_DATA,     8'h00, "data_after_rst");

    // Write DIR and DATA, check pads and readback.
    bus_write(REG_DIR, 8'hA5);
    check("oe8_after_dir_wr", gpio_oe8, 8'hA5);
    check("oe4_after_dir_wr", gpio_oe4, 4'h5);
    bus_write(REG_DATA, 8'h3C);
    check("out8_after_data_wr", gpio_out8, 8'h3C);
    check("out4_after_data_wr", gpio_out4, 4'hC);
    bus_read(REG_DIR,    8'hA5, "dir_readback");
    bus_read(REG_DATA,   8'h00, "data_read_is_pins");
    bus_read(REG_IRQ_EN, 8'h00, "irq_en_reset_value");

    // Synchronizer latency: pins change, DATA shows it on the third read.
    gpio_in = 8'h81;
    bus_read(REG_DATA, 8'h00, "sync_lat_c1");
    bus_read(REG_DATA, 8'h00, "sync_lat_c2");
    bus_read(REG_DATA, 8'h81, "sync_lat_c3");
    bus_read(REG_IRQ_STAT, 8'h81, "stat_rise_edges");
    bus_read(REG_IRQ_STAT, 8'h81, "stat_read_not_clear");
    check("irq_masked", irq8, 1'b0);

    // Interrupt path on pin 0 (configured as output, edges still count).
    bus_write(REG_IRQ_STAT, 8'hFF);
    bus_read(REG_IRQ_STAT, 8'h00, "stat_w1c_all");
    bus_write(REG_IRQ_EN, 8'h01);
    bus_read(REG_IRQ_EN, 8'h01, "irq_en_readback");
    check("irq_idle", irq8, 1'b0);
    gpio_in = 8'h80;
    for (int i = 0; i < 4; i++) begin
      bus_read(REG_IRQ_STAT, exp_stat_seq[i], "stat_pin0_fall");
      check("irq_rise_timing", irq8, exp_irq_seq[i]);
    end
    bus_write(REG_IRQ_STAT, 8'h00);
    bus_read(REG_IRQ_STAT, 8'h01, "stat_w1c_zero_keeps");
    check("irq_held", irq8, 1'b1);
    bus_write(REG_IRQ_STAT, 8'h01);
    check("irq_one_cycle_after_clear", irq8, 1'b1);
    idle();
    check("irq_fall", irq8, 1'b0);
    bus_read(REG_IRQ_STAT, 8'h00, "stat_pin0_cleared");

    // Collision: W1C of bit 1 on the edge that sets it.
    gpio_in = 8'h82;
    idle();
    idle();
    bus_write(REG_IRQ_STAT, 8'h02);
    bus_read(REG_IRQ_STAT, 8'h02, "collision_set_wins");
    bus_write(REG_IRQ_STAT, 8'h02);
    bus_read(REG_IRQ_STAT, 8'h00, "stat_pin1_cleared");
    check("irq_pin1_masked", irq8, 1'b0);

    // Narrow instance: upper bits read zero.
    bus_write(REG_DIR, 8'hFF);
    check("oe8_full", gpio_oe8, 8'hFF);
    check("oe4_full", gpio_oe4, 4'hF);
    bus_read(REG_DIR, 8'hFF, "dir8_full_read");
    check("dir4_read_upper_zero", rdata4, 8'h0F);

    // Reset during a write: write discarded, everything cleared.
    rst_n    = 1'b0;
    REGSEL   = REG_IRQ_EN;
    BUSWDATA = 8'hFF;
    BUSW     = 1'b1;
    BUSEN    = 1'b1;
    @(negedge clk);
    BUSEN = 1'b0;
    BUSW  = 1'b0;
    rst_n = 1'b1;
    check("midrst_oe8",  gpio_oe8, 8'h00);
    check("midrst_out8", gpio_out8, 8'h00);
    check("midrst_irq8", irq8, 1'b0);
    bus_read(REG_IRQ_EN, 8'h00, "midrst_irq_en");
    bus_read(REG_DIR,    8'h00, "midrst_dir");

    idle();
    idle();
    check("sb_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_regs.md
GPIO_REGS -- requirements
Module: gpio_regs

Interface
REQ-001 Parameter WIDTH, default 8, pin count; SHALL be 1..8 so that it fits the 8-bit bus.
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth; SHALL be at least 2.
REQ-003 Port clk, input, 1, single clock for the whole block.
REQ-004 Port rst_n, input, 1, synchronous active-low reset.
REQ-005 Port REGSEL, input, 2, register select from the bus interface.
REQ-006 Port BUSW, input, 1, access direction: 1 = write, 0 = read.
REQ-007 Port BUSEN, input, 1, one-cycle access strobe; a write SHALL occur only when BUSEN=1 and BUSW=1.
REQ-008 Port BUSWDATA, input, 8, write data.
REQ-009 Port BUSRDATA, output, 8, registered read data.
REQ-010 Port gpio_in, input, WIDTH, asynchronous pad inputs.
REQ-011 Port gpio_out, output, WIDTH, output data to the pads.
REQ-012 Port gpio_oe, output, WIDTH, per-pin output enable (1 = drive).
REQ-013 Port irq, output, 1, level interrupt.

Function
REQ-014 Register map SHALL be:
- 0 DATA: write sets the output register; read returns synchronized pin values.
- 1 DIR: read/write.
- 2 IRQ_EN: read/write.
- 3 IRQ_STAT: read returns status; write is write-1-to-clear.
REQ-015 Writes SHALL take effect on the clk edge at which BUSEN=1 and BUSW=1, using only BUSWDATA[WIDTH-1:0].
REQ-016 BUSRDATA SHALL update every cycle to the register addressed by REGSEL, one cycle after REGSEL is presented (1-cycle latency), regardless of BUSEN.
REQ-017 Unimplemented bits [7:WIDTH] SHALL read 0.
REQ-018 gpio_out SHALL equal the DATA output register.
REQ-019 gpio_oe SHALL equal DIR.
REQ-020 gpio_in SHALL pass through a SYNC_STAGES-flop synchronizer, followed by one history flop for edge detection.
REQ-021 An edge on a pin SHALL set its IRQ_STAT bit on the cycle after the synchronized value differs from the history flop; rising and falling edges both count.
REQ-022 IRQ_STAT bits SHALL set regardless of IRQ_EN.
REQ-023 IRQ_STAT bits SHALL stay set until cleared by a W1C write.
REQ-024 Reading IRQ_STAT SHALL NOT clear it.
REQ-025 If an edge on a pin and a W1C of that pin's bit occur in the same cycle, the set SHALL win and the bit SHALL remain 1.
REQ-026 Writing 0 to any IRQ_STAT bit SHALL leave that bit unchanged.
REQ-027 irq SHALL be registered and SHALL equal OR(IRQ_STAT & IRQ_EN) with one cycle of latency.
REQ-028 Edge detection SHALL operate whether or not a pin is configured as an output (DIR=1).
REQ-029 A write with REGSEL=0 SHALL NOT affect the DATA read value except through the pins.

Reset
REQ-030 While rst_n=0 at a clk edge, the following SHALL become 0: DATA out, DIR, IRQ_EN, IRQ_STAT, BUSRDATA, irq, all synchronizer flops and the history flop.
REQ-031 No edge SHALL be detected on the first cycle after reset release; the history flop SHALL be loaded from the synchronizer during that cycle without setting status.
REQ-032 A reset asserted mid-access SHALL discard the write; no register SHALL hold a partial update.

Structure
REQ-033 Register-index constants (DATA, DIR, IRQ_EN, IRQ_STAT) and the bus width constant 8 SHALL live in the shared package gpio_pkg.
REQ-034 The synchronizer SHALL be a sub-module gpio_sync, parameterized by WIDTH and SYNC_STAGES, with reset to 0.
REQ-035 All remaining logic SHALL reside in gpio_regs.

Verification
REQ-036 Reset: hold rst_n=0 for 3 cycles with gpio_in=8'hFF -> all outputs are 0, and IRQ_STAT reads 8'h00 after release.
REQ-037 Write then read: write DIR=8'hA5 and DATA=8'h3C -> gpio_oe=8'hA5 and gpio_out=8'h3C on the next cycle; a DIR read returns 8'hA5 one cycle after REGSEL=1.
REQ-038 Input sync: change gpio_in from 8'h00 to 8'h81 -> DATA read returns 8'h81 no earlier than SYNC_STAGES+1 cycles after the change; IRQ_STAT becomes 8'h81.
REQ-039 Interrupt: IRQ_EN=8'h01, edge on pin 0 -> irq rises 1 cycle after the status bit sets; W1C 8'h01 -> irq falls; W1C 8'h00 -> status unchanged.
REQ-040 Collision: W1C 8'h02 on the same cycle as a pin-1 edge is detected -> IRQ_STAT[1] remains 1.
REQ-041 Parameter sweep: WIDTH=4, write 8'hFF to DIR -> DIR reads 8'h0F.
